// File: rtl/muldiv_alu.sv
// rtl/muldiv_alu.sv - integer ALU with optional iterative multiply/divide group (macro MULDIV_EN)
module muldiv_alu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam int SHW = $clog2(XLEN);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;

   logic            accept;
   logic            accept_long;
   logic [XLEN-1:0] accept_res;
   logic [XLEN-1:0] base_res;
   logic [XLEN-1:0] sra_res;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] result_q;

   assign shamt   = b[SHW-1:0];
   assign sra_res = $signed(a) >>> shamt;
   assign accept  = in_valid & in_ready;
   assign result  = result_q;

   // single-cycle base operations, evaluated on the live operands at accept
   always_comb begin
      base_res = '0;
      case (funct3)
         3'b000:  base_res = funct7[5] ? (a - b) : (a + b);
         3'b001:  base_res = a << shamt;
         3'b010:  base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         3'b011:  base_res = {{(XLEN-1){1'b0}}, (a < b)};
         3'b100:  base_res = a ^ b;
         3'b101:  base_res = funct7[5] ? sra_res : (a >> shamt);
         3'b110:  base_res = a | b;
         default: base_res = a & b;
      endcase
   end

`ifdef MULDIV_EN
   logic              is_m;
   logic              is_div;
   logic              sgn_a;
   logic              sgn_b;
   logic              a_neg;
   logic              b_neg;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic [XLEN-1:0]   m_fast_res;
   logic [SHW-1:0]    cnt;
   logic [XLEN-1:0]   acc_hi;
   logic [XLEN-1:0]   acc_lo;
   logic [XLEN-1:0]   opnd;
   logic [2:0]        op_q;
   logic              neg_q;
   logic              neg_r;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     div_shift;
   logic [XLEN:0]     div_diff;
   logic [XLEN-1:0]   step_hi;
   logic [XLEN-1:0]   step_lo;
   logic [2*XLEN-1:0] prod;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   m_final;
   logic              last_iter;

   assign is_m   = (funct7 == 7'b0000001);
   assign is_div = funct3[2];

   // multiplies sign a except MULHU and sign b only for MUL/MULH; DIV/REM sign both
   assign sgn_a = is_div ? !funct3[0] : (funct3[1:0] != 2'b11);
   assign sgn_b = is_div ? !funct3[0] : !funct3[1];
   assign a_neg = sgn_a & a[XLEN-1];
   assign b_neg = sgn_b & b[XLEN-1];
   assign abs_a = a_neg ? -a : a;
   assign abs_b = b_neg ? -b : b;

   // the two divide corner cases finish immediately without iterating
   assign div_zero   = is_div && (b == '0);
   assign div_ovf    = is_div && !funct3[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign m_fast_res = div_zero ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);

   assign accept_long = is_m && !div_zero && !div_ovf;
   assign accept_res  = is_m ? m_fast_res : base_res;

   // one shift-add step (acc_lo holds the multiplier) or one restoring-divide step
   // (acc_lo holds the dividend shifting out / quotient shifting in, acc_hi the remainder)
   assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
   assign div_shift = {acc_hi, acc_lo[XLEN-1]};
   assign div_diff  = div_shift - {1'b0, opnd};

   // select the step result for the operation in flight
   always_comb begin
      step_hi = mul_sum[XLEN:1];
      step_lo = {mul_sum[0], acc_lo[XLEN-1:1]};
      if (op_q[2]) begin
         if (!div_diff[XLEN]) begin
            step_hi = div_diff[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b1};
         end else begin
            step_hi = div_shift[XLEN-1:0];
            step_lo = {acc_lo[XLEN-2:0], 1'b0};
         end
      end
   end

   // magnitudes were iterated; restore signs on the final step's value
   assign prod     = {step_hi, step_lo};
   assign prod_fix = neg_q ? -prod : prod;
   assign quo      = neg_q ? -step_lo : step_lo;
   assign rem      = neg_r ? -step_hi : step_hi;
   assign m_final  = op_q[2] ? (op_q[1] ? rem : quo)
                             : ((op_q[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

   assign last_iter = (state == CALC) && (cnt == SHW'(XLEN-1));

   // iteration state: loaded on an iterative accept, stepped every CALC cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt    <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd   <= '0;
         op_q   <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
      end else if (accept && accept_long) begin
         cnt    <= '0;
         acc_hi <= '0;
         op_q   <= funct3;
         neg_q  <= a_neg ^ b_neg;
         if (is_div) begin
            acc_lo <= abs_a;
            opnd   <= abs_b;
            neg_r  <= a_neg;
         end else begin
            acc_lo <= abs_b;
            opnd   <= abs_a;
            neg_r  <= 1'b0;
         end
      end else if (state == CALC) begin
         cnt    <= cnt + 1'b1;
         acc_hi <= step_hi;
         acc_lo <= step_lo;
      end
   end
`else
   logic unused_funct7;

   assign unused_funct7 = ^{funct7[6], funct7[4:0]};
   assign accept_long   = 1'b0;
   assign accept_res    = base_res;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next state and handshake outputs
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = accept_long ? CALC : DONE;
         end
`ifdef MULDIV_EN
         CALC: begin
            busy = 1'b1;
            if (last_iter) state_nxt = DONE;
         end
`endif
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
            if (out_ready) state_nxt = in_valid ? (accept_long ? CALC : DONE) : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // result register: loaded on a single-cycle accept or after the last iteration
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         result_q <= '0;
      end else if (accept && !accept_long) begin
         result_q <= accept_res;
`ifdef MULDIV_EN
      end else if (last_iter) begin
         result_q <= m_final;
`endif
      end
   end
endmodule

// File: tb/tb_muldiv_alu.sv
// tb/tb_muldiv_alu.sv - scoreboard bench for muldiv_alu
module tb_muldiv_alu;
   localparam int XLEN = 32;
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_M    = 7'b0000001;

   typedef struct {
      logic [XLEN-1:0] res;
      int              lat;
      int              busy_n;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   muldiv_alu #(.XLEN(XLEN)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .funct3    (funct3),
      .funct7    (funct7),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // drive one request, wait for its result, compare against the scoreboard
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [XLEN-1:0] oa, input logic [XLEN-1:0] ob,
                         input logic [XLEN-1:0] res, input int lat, input int busy_n);
      exp_t e;
      exp_t got;
      int   wait_n;
      int   l;
      int   bn;
      e.res = res; e.lat = lat; e.busy_n = busy_n;
      sb.push_back(e);
      funct3 = f3; funct7 = f7; a = oa; b = ob; in_valid = 1'b1;
      wait_n = 0;
      while (!in_ready && wait_n < 100) begin
         @(posedge clk); #1; wait_n++;
      end
      check({tag, " ready"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = $urandom; b = $urandom;
      l = 1; bn = 0;
      while (!out_valid && l < 100) begin
         bn += busy;
         @(posedge clk); #1; l++;
      end
      got = sb.pop_front();
      check({tag, " result"}, result, got.res);
      check({tag, " latency"}, l, got.lat);
      check({tag, " busy_cycles"}, bn, got.busy_n);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; funct3 = '0; funct7 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset result", result, 0);
      check("reset in_ready", in_ready, 1);
      rst_n = 1'b1;

      run_op("add_wrap", 3'b000, F7_BASE, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 0);
      run_op("sub",      3'b000, F7_ALT,  32'h0, 32'h1, 32'hFFFFFFFF, 1, 0);
      run_op("sra",      3'b101, F7_ALT,  32'h80000000, 32'h24, 32'hF8000000, 1, 0);
      run_op("srl",      3'b101, F7_BASE, 32'h80000000, 32'h24, 32'h08000000, 1, 0);
      run_op("sltu",     3'b011, F7_BASE, 32'h1, 32'hFFFFFFFF, 32'h1, 1, 0);
      run_op("slt",      3'b010, F7_BASE, 32'h1, 32'hFFFFFFFF, 32'h0, 1, 0);
      run_op("sll",      3'b001, F7_BASE, 32'h00000003, 32'h3F, 32'h80000000, 1, 0);
      run_op("xor",      3'b100, F7_BASE, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1, 0);
      run_op("or",       3'b110, F7_BASE, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1, 0);

`ifdef MULDIV_EN
      run_op("mulh",     3'b001, F7_M, 32'hFFFFFFFE, 32'h3, 32'hFFFFFFFF, 33, 32);
      run_op("mulhu",    3'b011, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 32);
      run_op("mul",      3'b000, F7_M, 32'hFFFFFFF9, 32'h6, 32'hFFFFFFD6, 33, 32);
      run_op("mulhsu",   3'b010, F7_M, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 32);
      run_op("div",      3'b100, F7_M, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 33, 32);
      run_op("rem",      3'b110, F7_M, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 33, 32);
      run_op("divu",     3'b101, F7_M, 32'd100, 32'd7, 32'd14, 33, 32);
      run_op("remu",     3'b111, F7_M, 32'd100, 32'd7, 32'd2, 33, 32);
      run_op("divu_z",   3'b101, F7_M, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 0);
      run_op("remu_z",   3'b111, F7_M, 32'd5, 32'd0, 32'd5, 1, 0);
      run_op("div_ovf",  3'b100, F7_M, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0);
      run_op("rem_ovf",  3'b110, F7_M, 32'h80000000, 32'hFFFFFFFF, 32'h0, 1, 0);
`else
      run_op("m_as_add", 3'b000, F7_M, 32'd40, 32'd2, 32'd42, 1, 0);
      run_op("m_as_srl", 3'b101, F7_M, 32'h80000000, 32'h4, 32'h08000000, 1, 0);
`endif

      // DONE hold with out_ready low, a pending request must wait
      run_op("and", 3'b111, F7_BASE, 32'h0F0F0F0F, 32'h00FF00FF, 32'h000F000F, 1, 0);
      out_ready = 1'b0;
      begin
         exp_t e;
         exp_t got;
         e.res = 32'd30; e.lat = 1; e.busy_n = 0;
         sb.push_back(e);
         funct3 = 3'b000; funct7 = F7_BASE; a = 32'd10; b = 32'd20; in_valid = 1'b1;
         for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("hold result", result, 32'h000F000F);
            check("hold out_valid", out_valid, 1);
            check("hold in_ready", in_ready, 0);
         end
         out_ready = 1'b1;
         #1;
         check("b2b in_ready", in_ready, 1);
         @(posedge clk); #1;
         in_valid = 1'b0;
         got = sb.pop_front();
         check("b2b out_valid", out_valid, 1);
         check("b2b result", result, got.res);
      end

      // reset mid-operation aborts it
`ifdef MULDIV_EN
      funct3 = 3'b100; funct7 = F7_M; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (9) begin
         @(posedge clk); #1;
      end
      check("calc10 busy", busy, 1);
      check("calc10 in_ready", in_ready, 0);
`else
      out_ready = 1'b0;
      funct3 = 3'b000; funct7 = F7_BASE; a = 32'd9; b = 32'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("done_pre_rst out_valid", out_valid, 1);
`endif
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort out_valid", out_valid, 0);
      check("abort busy", busy, 0);
      check("abort result", result, 0);
      rst_n = 1'b1;
      out_ready = 1'b1;
      check("post_rst in_ready", in_ready, 1);
      repeat (2) begin
         @(posedge clk); #1;
         check("post_rst no out_valid", out_valid, 0);
      end
      run_op("add_after_rst", 3'b000, F7_BASE, 32'd2, 32'd3, 32'd5, 1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_alu.md
MULDIV_ALU -- requirements
Module: muldiv_alu

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width; legal values are 32 and 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operation request is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-006 The block SHALL have ports a and b, input, XLEN bits each: the operands.
REQ-007 The block SHALL have port funct3, input, 3 bits: the operation select.
REQ-008 The block SHALL have port funct7, input, 7 bits: bit 5 selects SUB/SRA, and value 7'b0000001 selects the M group.
REQ-009 The block SHALL have port out_valid, output, 1 bit: result is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port result, output, XLEN bits: the operation result.
REQ-012 The block SHALL have port busy, output, 1 bit: an iterative M operation is in progress.

Function
REQ-013 A request SHALL be accepted on any rising edge where in_valid and in_ready are both 1; a, b, funct3 and funct7 SHALL be captured at that edge.
REQ-014 The state machine SHALL have three states: IDLE, CALC and DONE; in_ready SHALL be 1 in IDLE, and in DONE when out_ready is 1 (back-to-back accept); otherwise 0.
REQ-015 A base operation (funct7 other than 0000001) SHALL go IDLE/DONE->DONE with result registered, giving out_valid one cycle after acceptance.
REQ-016 The base operations by funct3 SHALL be: 000 ADD/SUB; 001 SLL; 010 SLT (signed); 011 SLTU; 100 XOR; 101 SRL/SRA; 110 OR; 111 AND.
REQ-017 The shift amount SHALL be b[$clog2(XLEN)-1:0]; SLT/SLTU SHALL return zero-extended 0 or 1; ADD/SUB SHALL wrap modulo 2^XLEN.
REQ-018 The M operations by funct3 SHALL be: 000 MUL (low half); 001 MULH (s×s); 010 MULHSU (s×u); 011 MULHU (u×u); 100 DIV; 101 DIVU; 110 REM; 111 REMU.
REQ-019 An M operation SHALL enter CALC, run exactly XLEN iterations (shift-add multiply, restoring divide) with busy=1, then enter DONE, so out_valid rises XLEN+1 cycles after acceptance.
REQ-020 Divide-by-zero SHALL go directly to DONE (latency 1) with quotient all-ones and remainder equal to a.
REQ-021 Signed overflow (a = most-negative, b = -1) SHALL go directly to DONE (latency 1) with quotient equal to a and remainder 0.
REQ-022 For signed DIV/REM, the quotient sign SHALL be sign(a) XOR sign(b), the remainder sign SHALL follow a, and the quotient SHALL be truncated toward zero.
REQ-023 In DONE with out_ready=0, result and out_valid SHALL hold stable, and the block SHALL accept no new request.
REQ-024 In DONE with out_ready=1 and no new accept, the state SHALL return to IDLE and out_valid SHALL drop next cycle.
REQ-025 In CALC, in_valid, a and b SHALL be ignored, and out_ready SHALL have no effect.

Reset
REQ-026 With rst_n=0 at a rising edge, the state SHALL become IDLE, out_valid 0, busy 0, result 0, the iteration counter 0 and the internal accumulators 0.
REQ-027 Reset asserted mid-CALC or mid-DONE SHALL abort the operation without producing out_valid; in_ready SHALL be 1 in the first cycle after rst_n returns to 1.

Configuration
REQ-028 With macro MULDIV_EN defined, the M group SHALL be implemented per REQ-018 to REQ-022.
REQ-029 Without MULDIV_EN, funct7=0000001 SHALL be treated as a base operation with funct7[5]=0 (latency 1), and no CALC state, counter or accumulator logic SHALL be synthesised; busy SHALL be tied to 0.

Verification
REQ-030 The bench SHALL check: XLEN=32, ADD a=32'h7FFFFFFF, b=1 -> result 32'h80000000, out_valid 1 cycle after accept; SUB a=0, b=1 -> 32'hFFFFFFFF.
REQ-031 The bench SHALL check: SRA a=32'h80000000, b=32'h24 (shamt 4) -> 32'hF8000000; SLTU a=1, b=32'hFFFFFFFF -> 1.
REQ-032 The bench SHALL check: MULH a=-2, b=3 -> 32'hFFFFFFFF; MULHU a=b=32'hFFFFFFFF -> 32'hFFFFFFFE; out_valid exactly 33 cycles after accept, busy high for 32 cycles.
REQ-033 The bench SHALL check: DIV a=-7, b=2 -> -3; REM -> -1; DIVU a=5, b=0 -> 32'hFFFFFFFF at latency 1; DIV a=32'h80000000, b=-1 -> 32'h80000000.
REQ-034 The bench SHALL check: out_ready held 0 for 5 cycles in DONE -> result stable and in_ready 0; then out_ready=1 with in_valid=1 -> new request accepted the same cycle.
REQ-035 The bench SHALL check: rst_n=0 at CALC cycle 10 of a DIV -> no out_valid, busy 0 next cycle; a following ADD 2+3 -> 5.
